// File: rtl/rhythm_controller.sv
// Beat-analysis sequencer: discards the first RR interval, learns a baseline,
// then classifies each beat as brady/tachy/irregular and raises asystole/alarm.
module rhythm_controller #(
  parameter int unsigned LEARN_BEATS = 8,
  parameter int unsigned TOL_SHIFT   = 3,
  parameter int unsigned BRADY_MS    = 1500,
  parameter int unsigned TACHY_MS    = 500,
  parameter int unsigned ASYS_MS     = 3000,
  parameter int unsigned IRR_LIMIT   = 3
) (
  input  logic        clk_div,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] rr_interval_ms,
  input  logic        new_rr_pulse,
  output logic [1:0]  state,
  output logic [11:0] baseline_ms,
  output logic        beat_valid,
  output logic        brady,
  output logic        tachy,
  output logic        irregular,
  output logic [2:0]  irr_count,
  output logic        asystole,
  output logic        alarm
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_LEARN   = 2'd2,
    ST_MONITOR = 2'd3
  } state_e;

  localparam int unsigned LEARN_LOG2 = $clog2(LEARN_BEATS);
  localparam logic [4:0]  LAST_CNT   = 5'(LEARN_BEATS - 1);
  localparam logic [11:0] ASYS_LIM   = 12'(ASYS_MS);
  localparam logic [11:0] BRADY_LIM  = 12'(BRADY_MS);
  localparam logic [11:0] TACHY_LIM  = 12'(TACHY_MS);
  localparam logic [2:0]  IRR_LIM    = 3'(IRR_LIMIT);
  localparam logic [11:0] RR_SAT     = '1;

  state_e      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] timer_q, timer_d;
  logic [11:0] baseline_q, baseline_d;
  logic        beat_valid_q, beat_valid_d;
  logic        brady_q, brady_d;
  logic        tachy_q, tachy_d;
  logic        irregular_q, irregular_d;
  logic [2:0]  irr_count_q, irr_count_d;
  logic        asystole_q, asystole_d;
  logic        alarm_q, alarm_d;

  logic [15:0] sum_acc;
  logic [11:0] rr_diff;
  logic [11:0] tol;
  logic        beat_irr;
  logic [11:0] base_track;
  logic [11:0] timer_next;
  logic        timed_out;

  always_comb begin
    sum_acc    = sum_q + {4'd0, rr_interval_ms};
    rr_diff    = (rr_interval_ms >= baseline_q) ? (rr_interval_ms - baseline_q)
                                                : (baseline_q - rr_interval_ms);
    tol        = baseline_q >> TOL_SHIFT;
    beat_irr   = rr_diff > tol;
    base_track = baseline_q - (baseline_q >> 3) + (rr_interval_ms >> 3);
    // Timer saturates at the limit, so timed_out stays true while silent.
    timer_next = (timer_q == ASYS_LIM) ? timer_q : timer_q + 12'd1;
    timed_out  = (timer_next == ASYS_LIM);

    state_d      = state_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    baseline_d   = baseline_q;
    beat_valid_d = 1'b0;
    brady_d      = brady_q;
    tachy_d      = tachy_q;
    irregular_d  = irregular_q;
    irr_count_d  = irr_count_q;
    asystole_d   = asystole_q;

    if (!enable) begin
      state_d     = ST_IDLE;
      sum_d       = '0;
      cnt_d       = '0;
      timer_d     = '0;
      baseline_d  = '0;
      brady_d     = 1'b0;
      tachy_d     = 1'b0;
      irregular_d = 1'b0;
      irr_count_d = '0;
      asystole_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (new_rr_pulse) begin
            state_d    = ST_LEARN;
            sum_d      = '0;
            cnt_d      = '0;
            timer_d    = '0;
            asystole_d = 1'b0;
          end
        end
        ST_LEARN: begin
          if (new_rr_pulse) begin
            timer_d    = '0;
            asystole_d = 1'b0;
            if (rr_interval_ms == RR_SAT) begin
              sum_d = '0;
              cnt_d = '0;
            end else if (cnt_q == LAST_CNT) begin
              baseline_d = 12'(sum_acc >> LEARN_LOG2);
              sum_d      = '0;
              cnt_d      = '0;
              state_d    = ST_MONITOR;
            end else begin
              sum_d = sum_acc;
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            timer_d = timer_next;
            if (timed_out) begin
              asystole_d = 1'b1;
              state_d    = ST_ARM;
              sum_d      = '0;
              cnt_d      = '0;
              timer_d    = '0;
            end
          end
        end
        ST_MONITOR: begin
          if (new_rr_pulse) begin
            timer_d      = '0;
            asystole_d   = 1'b0;
            beat_valid_d = 1'b1;
            brady_d      = rr_interval_ms > BRADY_LIM;
            tachy_d      = rr_interval_ms < TACHY_LIM;
            irregular_d  = beat_irr;
            if (beat_irr) begin
              irr_count_d = (irr_count_q == 3'd7) ? 3'd7 : irr_count_q + 3'd1;
            end else begin
              irr_count_d = '0;
              baseline_d  = base_track;
            end
          end else begin
            timer_d = timer_next;
            if (timed_out) asystole_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    alarm_d = asystole_d | (irr_count_d >= IRR_LIM);
  end

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sum_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      baseline_q   <= '0;
      beat_valid_q <= 1'b0;
      brady_q      <= 1'b0;
      tachy_q      <= 1'b0;
      irregular_q  <= 1'b0;
      irr_count_q  <= '0;
      asystole_q   <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      baseline_q   <= baseline_d;
      beat_valid_q <= beat_valid_d;
      brady_q      <= brady_d;
      tachy_q      <= tachy_d;
      irregular_q  <= irregular_d;
      irr_count_q  <= irr_count_d;
      asystole_q   <= asystole_d;
      alarm_q      <= alarm_d;
    end
  end

  assign state       = state_q;
  assign baseline_ms = baseline_q;
  assign beat_valid  = beat_valid_q;
  assign brady       = brady_q;
  assign tachy       = tachy_q;
  assign irregular   = irregular_q;
  assign irr_count   = irr_count_q;
  assign asystole    = asystole_q;
  assign alarm       = alarm_q;

endmodule
